// File: rtl/spu_sm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spu_sm_ctrl
// Description : Four-pass softmax sequencer (max, exp-sum, reciprocal,
//               exp-normalise write-back) driving spu_sm_block over one token.
// Revision    : 1.0 - initial release
// ============================================================================
module spu_sm_ctrl #(
    parameter int ADDR_W    = 9,
    parameter int MAX_LAT   = 1,
    parameter int ADDER_LAT = 2
) (
    input  logic              core_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   token_len,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [2:0]        sm_state,
    output logic              comp_en,
    output logic              comp_rst,
    output logic              adder_tree_en,
    output logic              adder_tree_clr,
    output logic              reci_exp_sum_en,
    input  logic              reci_exp_sum_finish,
    output logic [31:0]       sm_b_data_in,
    input  logic [31:0]       sm_b_data_out
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [CNT_W-1:0]  MAX_END  = CNT_W'(MAX_LAT);
    localparam logic [CNT_W-1:0]  ADD_END  = CNT_W'(ADDER_LAT);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_MAX       = 4'd1,
        S_MAX_DRAIN = 4'd2,
        S_EUA       = 4'd3,
        S_EUA_DRAIN = 4'd4,
        S_RECI_REQ  = 4'd5,
        S_RECI_WAIT = 4'd6,
        S_EUB       = 4'd7,
        S_EUB_DRAIN = 4'd8
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              vld;
    logic              done_nx;
    logic              last_rd;

    assign last_rd = (cnt == (len_q - CNT_ONE));

    always_ff @(posedge core_clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        done_nx         = 1'b0;
        rd_en           = 1'b0;
        comp_rst        = 1'b0;
        adder_tree_clr  = 1'b0;
        reci_exp_sum_en = 1'b0;
        sm_state        = 3'b000;
        case (state)
            S_IDLE: begin
                if (start) begin
                    comp_rst       = 1'b1;
                    adder_tree_clr = 1'b1;
                    if (token_len == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        state_nx = S_MAX;
                    end
                end
            end
            S_MAX: begin
                sm_state = 3'b101;
                rd_en    = 1'b1;
                if (last_rd) state_nx = S_MAX_DRAIN;
            end
            S_MAX_DRAIN: begin
                sm_state = 3'b101;
                if (cnt == MAX_END) state_nx = S_EUA;
            end
            S_EUA: begin
                sm_state = 3'b001;
                rd_en    = 1'b1;
                if (last_rd) state_nx = S_EUA_DRAIN;
            end
            S_EUA_DRAIN: begin
                sm_state = 3'b001;
                if (cnt == ADD_END) state_nx = S_RECI_REQ;
            end
            S_RECI_REQ: begin
                // A finish seen here belongs to no request yet, so it is dropped.
                sm_state        = 3'b011;
                reci_exp_sum_en = 1'b1;
                state_nx        = S_RECI_WAIT;
            end
            S_RECI_WAIT: begin
                sm_state = 3'b011;
                if (reci_exp_sum_finish) state_nx = S_EUB;
            end
            S_EUB: begin
                sm_state = 3'b100;
                rd_en    = 1'b1;
                if (last_rd) state_nx = S_EUB_DRAIN;
            end
            S_EUB_DRAIN: begin
                sm_state = 3'b100;
                done_nx  = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // cnt restarts on every state change so it doubles as read index and drain timer.
    always_ff @(posedge core_clk) begin
        if (rst) begin
            cnt    <= '0;
            len_q  <= '0;
            base_q <= '0;
            addr_q <= '0;
            addr_d <= '0;
            vld    <= 1'b0;
            done   <= 1'b0;
        end else begin
            vld    <= rd_en;
            addr_d <= rd_addr;
            done   <= done_nx;
            cnt    <= (state_nx != state) ? '0 : cnt + CNT_ONE;
            if (state == S_IDLE && start) begin
                len_q  <= token_len;
                base_q <= base_addr;
                addr_q <= base_addr;
            end else if (rd_en) begin
                addr_q <= addr_q + ADDR_ONE;
            end else begin
                addr_q <= base_q;
            end
        end
    end

    assign busy          = (state != S_IDLE);
    assign rd_addr       = rd_en ? addr_q : '0;
    assign comp_en       = vld && (state == S_MAX || state == S_MAX_DRAIN);
    assign adder_tree_en = vld && (state == S_EUA || state == S_EUA_DRAIN);
    assign wr_en         = vld && (state == S_EUB || state == S_EUB_DRAIN);
    assign wr_addr       = wr_en ? addr_d : '0;
    assign wr_data       = wr_en ? sm_b_data_out : '0;
    assign sm_b_data_in  = rd_data;

endmodule
`default_nettype wire

// File: doc/spu_sm_ctrl.md
# spu_sm_ctrl

Sequencer that drives the softmax datapath block (spu_sm_block) over one token held in the SPU token buffer. It runs four passes per token: max search, exp-sum accumulation, reciprocal, exp-normalise write-back. It issues buffer reads, generates the `sm_state` and enable strobes in the datapath's expected phase order, and writes the normalised bytes back to the buffer. It is the stage directly upstream of the datapath and owns its control inputs.

## Interface
- `ADDR_W`, 9: buffer word-address width (512 words × 4 bytes = 2048 elements).
- `MAX_LAT`, 1: cycles from last `comp_en` until the datapath `x_max` is stable.
- `ADDER_LAT`, 2: cycles from last `adder_tree_en` until `sm_sum_exp` is stable.

Ports:
- `core_clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin token; sampled only in IDLE.
- `token_len` in ADDR_W+1: token length in 32-bit words, 0..2^ADDR_W; sampled at start.
- `base_addr` in ADDR_W: first word address; sampled at start.
- `busy` out 1: high from the cycle after start acceptance until done.
- `done` out 1: one-cycle pulse at the end of a token.
- `rd_en` out 1, `rd_addr` out ADDR_W: buffer read; `rd_data` returns exactly 1 cycle later.
- `rd_data` in 32: buffer read data.
- `wr_en` out 1, `wr_addr` out ADDR_W, `wr_data` out 32: buffer write-back.
- `sm_state` out 3: datapath phase.
- `comp_en`, `comp_rst`, `adder_tree_en`, `adder_tree_clr`, `reci_exp_sum_en` out 1 each: datapath strobes.
- `reci_exp_sum_finish` in 1: divider acknowledge.
- `sm_b_data_in` out 32: combinationally equal to `rd_data`.
- `sm_b_data_out` in 32: datapath result.

## Operation
- States:
  - IDLE
  - MAX, MAX_DRAIN
  - EUA, EUA_DRAIN
  - RECI_REQ, RECI_WAIT
  - EUB, EUB_DRAIN
- `sm_state` encoding:
  - IDLE: 000
  - MAX and MAX_DRAIN: 101
  - EUA and EUA_DRAIN: 001
  - RECI_REQ and RECI_WAIT: 011
  - EUB and EUB_DRAIN: 100
- IDLE with `start`=1:
  - Latch N=`token_len` and `base_addr`.
  - Pulse `comp_rst` and `adder_tree_clr` in that same cycle.
  - If N=0, go to IDLE and pulse `done` next cycle; no reads or writes occur. Otherwise go to MAX.
- Read pass (MAX, EUA, EUB):
  - `rd_en`=1 for exactly N consecutive cycles.
  - `rd_addr` = `base_addr`+i, i=0..N-1, wrapping modulo 2^ADDR_W.
  - Internal `vld` = `rd_en` delayed 1 cycle; `addr_d` = `rd_addr` delayed 1 cycle.
- MAX: `comp_en`=`vld`. MAX_DRAIN lasts 1+MAX_LAT cycles (covers the last data return).
- EUA: `adder_tree_en`=`vld`. EUA_DRAIN lasts 1+ADDER_LAT cycles.
- RECI_REQ: one cycle with `reci_exp_sum_en`=1, then RECI_WAIT.
- RECI_WAIT: hold until `reci_exp_sum_finish`=1 is sampled, then go to EUB next cycle. A finish arriving in the RECI_REQ cycle itself is ignored.
- EUB:
  - `wr_en`=`vld`, `wr_addr`=`addr_d`, `wr_data`=`sm_b_data_out`. Write-back is in place.
  - EUB_DRAIN is 1 cycle (the last write); then IDLE with `done`=1 for one cycle.
- `start` while not IDLE is ignored. `start` in the `done` cycle is accepted (state is IDLE).
- Strobes are 0 in every state and cycle not listed above.

## Timing
- Reset: all outputs 0 (`sm_state`=000, `rd_addr`/`wr_addr`/`wr_data`=0); FSM to IDLE.
- `rst` mid-token aborts at the next edge. The in-flight `vld` is cleared, so no `wr_en` follows reset.
- Cycle counts for start accepted at cycle s, N≥1, divider finish sampled at cycle f:
  - MAX reads: s+1..s+N; `comp_en`: s+2..s+N+1.
  - EUA reads start at s+N+2+MAX_LAT.
  - RECI_REQ at s+2N+3+MAX_LAT+ADDER_LAT.
  - EUB reads start at f+1; writes at f+2..f+N+1.
  - `done` at f+N+2.
- `busy` = state≠IDLE.
- Address counter: ADDR_W bits. Pass counter: ADDR_W+1 bits, so N=2^ADDR_W is legal.

## Test plan
- N=4, base 0, MAX_LAT=1, ADDER_LAT=2, finish 3 cycles after `reci_exp_sum_en`:
  - `comp_en` s+2..s+5; `adder_tree_en` s+8..s+11; `reci_exp_sum_en` at s+14.
  - Finish at s+17; writes to addr 0..3 at s+19..s+22; `done` at s+23.
- N=1, base 511: all reads and the single write at addr 511; `done` at f+3.
- N=3, base 510: addresses 510, 511, 0 in every pass, including the writes.
- N=0: `comp_rst`/`adder_tree_clr` pulse at s; `done` at s+1; no `rd_en`/`wr_en`; `busy` stays 0.
- `start` pulsed every cycle during a token: exactly one token processed; the next is accepted in the `done` cycle.
- `rst` asserted in the second EUB read cycle: the next cycle shows all outputs 0 and IDLE, no further `wr_en`, and a new `start` works normally.
